// File: rtl/cpu_pkg.sv
// Shared widths and the issue-queue entry layout used across the core.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned IMM_W  = 8;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  rob_idx;
        logic [OPC_W-1:0]  opcode;
        logic [IMM_W-1:0]  imm;
        logic              a_valid;
        logic [DATA_W-1:0] a_value;
        logic [TAG_W-1:0]  a_owner;
        logic              b_valid;
        logic [DATA_W-1:0] b_value;
        logic [TAG_W-1:0]  b_owner;
    } iq_entry_t;

endpackage

// File: rtl/iq_age_select.sv
// Combinational oldest-ready picker: smallest (rob_idx - rob_head) wins,
// ties resolved towards the lowest entry index.
module iq_age_select
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]            rob_head,
    output logic [DEPTH-1:0]            grant,
    output logic                        any_ready
);

    logic [TAG_W-1:0] best_age;
    logic [TAG_W-1:0] age;

    always_comb begin
        grant     = '0;
        any_ready = 1'b0;
        best_age  = '0;
        age       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = tags[i] - rob_head;
            // Strict compare keeps the lower index on equal age.
            if (ready[i] && (!any_ready || age < best_age)) begin
                grant     = '0;
                grant[i]  = 1'b1;
                any_ready = 1'b1;
                best_age  = age;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Issue queue: holds dispatched micro-ops, snoops the CDB for missing operands
// and issues the oldest ready op through a registered valid/ready stage.
module issue_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NUM_CDB = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [TAG_W-1:0]            rob_head,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [TAG_W-1:0]            in_rob_idx,
    input  logic [OPC_W-1:0]            in_opcode,
    input  logic [IMM_W-1:0]            in_imm,
    input  logic                        in_a_valid,
    input  logic                        in_b_valid,
    input  logic [DATA_W-1:0]           in_a_value,
    input  logic [DATA_W-1:0]           in_b_value,
    input  logic [TAG_W-1:0]            in_a_owner,
    input  logic [TAG_W-1:0]            in_b_owner,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [TAG_W-1:0]            issue_rob_idx,
    output logic [OPC_W-1:0]            issue_opcode,
    output logic [IMM_W-1:0]            issue_imm,
    output logic [DATA_W-1:0]           issue_a,
    output logic [DATA_W-1:0]           issue_b,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    iq_entry_t entries_q [DEPTH];
    iq_entry_t entries_d [DEPTH];
    iq_entry_t in_entry;

    logic [DEPTH-1:0]            ready;
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0]            grant;
    logic [DEPTH-1:0]            free_oh;
    logic [DEPTH-1:0][TAG_W-1:0] tags;
    logic                        any_ready;
    logic                        load;
    logic                        dispatch;
    logic [CNT_W-1:0]            count_q;
    logic [CNT_W-1:0]            count_d;
    logic                        out_valid_q;

    logic [TAG_W-1:0]  sel_rob;
    logic [OPC_W-1:0]  sel_opc;
    logic [IMM_W-1:0]  sel_imm;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    logic [TAG_W-1:0]  out_rob_q;
    logic [OPC_W-1:0]  out_opc_q;
    logic [IMM_W-1:0]  out_imm_q;
    logic [DATA_W-1:0] out_a_q;
    logic [DATA_W-1:0] out_b_q;

    // Returns {valid, value}; the lowest matching CDB channel wins.
    function automatic logic [DATA_W:0] snoop(
        input logic                      v,
        input logic [DATA_W-1:0]         value,
        input logic [TAG_W-1:0]          owner,
        input logic [NUM_CDB-1:0]        cv,
        input logic [NUM_CDB*TAG_W-1:0]  ct,
        input logic [NUM_CDB*DATA_W-1:0] cd
    );
        logic [DATA_W:0] r;
        r = {v, value};
        if (!v) begin
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cv[k] && ct[k*TAG_W +: TAG_W] == owner) begin
                    r = {1'b1, cd[k*DATA_W +: DATA_W]};
                end
            end
        end
        return r;
    endfunction

    assign in_ready    = (count_q < CNT_W'(DEPTH));
    assign dispatch    = in_valid & in_ready;
    assign load        = any_ready & (~out_valid_q | issue_ready);
    assign count       = count_q;
    assign issue_valid = out_valid_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            vld[i]   = entries_q[i].valid;
            ready[i] = entries_q[i].valid & entries_q[i].a_valid & entries_q[i].b_valid;
            tags[i]  = entries_q[i].rob_idx;
        end
    end

    // Lowest clear bit of the occupancy vector.
    assign free_oh = ~vld & (vld + DEPTH'(1));

    iq_age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .ready     (ready),
        .tags      (tags),
        .rob_head  (rob_head),
        .grant     (grant),
        .any_ready (any_ready)
    );

    always_comb begin
        sel_rob = '0;
        sel_opc = '0;
        sel_imm = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_rob = entries_q[i].rob_idx;
                sel_opc = entries_q[i].opcode;
                sel_imm = entries_q[i].imm;
                sel_a   = entries_q[i].a_value;
                sel_b   = entries_q[i].b_value;
            end
        end
    end

    always_comb begin
        in_entry         = '0;
        in_entry.valid   = 1'b1;
        in_entry.rob_idx = in_rob_idx;
        in_entry.opcode  = in_opcode;
        in_entry.imm     = in_imm;
        in_entry.a_owner = in_a_owner;
        in_entry.b_owner = in_b_owner;
        {in_entry.a_valid, in_entry.a_value} =
            snoop(in_a_valid, in_a_value, in_a_owner, cdb_valid, cdb_tag, cdb_data);
        {in_entry.b_valid, in_entry.b_value} =
            snoop(in_b_valid, in_b_value, in_b_owner, cdb_valid, cdb_tag, cdb_data);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            {entries_d[i].a_valid, entries_d[i].a_value} = snoop(entries_q[i].a_valid,
                entries_q[i].a_value, entries_q[i].a_owner, cdb_valid, cdb_tag, cdb_data);
            {entries_d[i].b_valid, entries_d[i].b_value} = snoop(entries_q[i].b_valid,
                entries_q[i].b_value, entries_q[i].b_owner, cdb_valid, cdb_tag, cdb_data);
            if (load && grant[i]) begin
                entries_d[i].valid = 1'b0;
            end
            if (dispatch && free_oh[i]) begin
                entries_d[i] = in_entry;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({dispatch, load})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
            if (load) begin
                out_valid_q <= 1'b1;
            end else if (issue_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rob_q <= '0;
            out_opc_q <= '0;
            out_imm_q <= '0;
            out_a_q   <= '0;
            out_b_q   <= '0;
        end else if (load && !flush) begin
            out_rob_q <= sel_rob;
            out_opc_q <= sel_opc;
            out_imm_q <= sel_imm;
            out_a_q   <= sel_a;
            out_b_q   <= sel_b;
        end
    end

    assign issue_rob_idx = out_rob_q;
    assign issue_opcode  = out_opc_q;
    assign issue_imm     = out_imm_q;
    assign issue_a       = out_a_q;
    assign issue_b       = out_b_q;

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic, checked by a
// queue-based reference model and an independent issue monitor.
module tb_issue_queue;
    import cpu_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned NUM_CDB = 4;
    localparam int          NTAGS   = 2 ** TAG_W;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       flush = 1'b0;
    logic [TAG_W-1:0]           rob_head = '0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [TAG_W-1:0]           in_rob_idx = '0;
    logic [OPC_W-1:0]           in_opcode = '0;
    logic [IMM_W-1:0]           in_imm = '0;
    logic                       in_a_valid = 1'b0;
    logic                       in_b_valid = 1'b0;
    logic [DATA_W-1:0]          in_a_value = '0;
    logic [DATA_W-1:0]          in_b_value = '0;
    logic [TAG_W-1:0]           in_a_owner = '0;
    logic [TAG_W-1:0]           in_b_owner = '0;
    logic [NUM_CDB-1:0]         cdb_valid = '0;
    logic [NUM_CDB*TAG_W-1:0]   cdb_tag = '0;
    logic [NUM_CDB*DATA_W-1:0]  cdb_data = '0;
    logic                       issue_valid;
    logic                       issue_ready = 1'b1;
    logic [TAG_W-1:0]           issue_rob_idx;
    logic [OPC_W-1:0]           issue_opcode;
    logic [IMM_W-1:0]           issue_imm;
    logic [DATA_W-1:0]          issue_a;
    logic [DATA_W-1:0]          issue_b;
    logic [$clog2(DEPTH+1)-1:0] count;

    issue_queue #(
        .DEPTH   (DEPTH),
        .NUM_CDB (NUM_CDB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .rob_head      (rob_head),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rob_idx    (in_rob_idx),
        .in_opcode     (in_opcode),
        .in_imm        (in_imm),
        .in_a_valid    (in_a_valid),
        .in_b_valid    (in_b_valid),
        .in_a_value    (in_a_value),
        .in_b_value    (in_b_value),
        .in_a_owner    (in_a_owner),
        .in_b_owner    (in_b_owner),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_rob_idx (issue_rob_idx),
        .issue_opcode  (issue_opcode),
        .issue_imm     (issue_imm),
        .issue_a       (issue_a),
        .issue_b       (issue_b),
        .count         (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [OPC_W-1:0]  opc;
        logic [IMM_W-1:0]  imm;
        bit                av;
        bit                bv;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  ao;
        logic [TAG_W-1:0]  bo;
    } op_t;

    op_t pool[$];   // ops waiting in the queue
    op_t expq[$];   // ops expected to appear on the issue port, in order
    bit  m_out_valid = 1'b0;
    int  checks = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cdb_chan(input logic [TAG_W-1:0] owner);
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == owner) return k;
        end
        return -1;
    endfunction

    function automatic bit tag_used(input logic [TAG_W-1:0] t);
        foreach (pool[i]) if (pool[i].tag == t) return 1'b1;
        foreach (expq[i]) if (expq[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of the reference model, evaluated on the inputs of this cycle.
    task automatic model_step();
        int  n;
        int  best;
        int  best_age;
        int  age;
        int  k;
        op_t op;
        n = pool.size();
        check("count", 64'(count), 64'(n));
        check("in_ready", 64'(in_ready), 64'(n < DEPTH));
        check("issue_valid", 64'(issue_valid), 64'(m_out_valid));
        if (flush) begin
            pool.delete();
            expq.delete();
            m_out_valid = 1'b0;
            return;
        end
        if (!m_out_valid || issue_ready) begin
            best = -1;
            best_age = NTAGS;
            foreach (pool[i]) begin
                if (pool[i].av && pool[i].bv) begin
                    age = (int'(pool[i].tag) - int'(rob_head) + NTAGS) % NTAGS;
                    if (age < best_age) begin
                        best = i;
                        best_age = age;
                    end
                end
            end
            if (best >= 0) begin
                expq.push_back(pool[best]);
                pool.delete(best);
                m_out_valid = 1'b1;
            end else begin
                m_out_valid = 1'b0;
            end
        end
        foreach (pool[i]) begin
            op = pool[i];
            k = cdb_chan(op.ao);
            if (!op.av && k >= 0) begin
                op.av = 1'b1;
                op.a = cdb_data[k*DATA_W +: DATA_W];
            end
            k = cdb_chan(op.bo);
            if (!op.bv && k >= 0) begin
                op.bv = 1'b1;
                op.b = cdb_data[k*DATA_W +: DATA_W];
            end
            pool[i] = op;
        end
        if (in_valid && n < DEPTH) begin
            op.tag = in_rob_idx;
            op.opc = in_opcode;
            op.imm = in_imm;
            op.av = in_a_valid;
            op.a = in_a_value;
            op.ao = in_a_owner;
            op.bv = in_b_valid;
            op.b = in_b_value;
            op.bo = in_b_owner;
            k = cdb_chan(in_a_owner);
            if (!op.av && k >= 0) begin
                op.av = 1'b1;
                op.a = cdb_data[k*DATA_W +: DATA_W];
            end
            k = cdb_chan(in_b_owner);
            if (!op.bv && k >= 0) begin
                op.bv = 1'b1;
                op.b = cdb_data[k*DATA_W +: DATA_W];
            end
            pool.push_back(op);
        end
    endtask

    // Monitor: pops the expected op on every accepted issue and checks hold during stalls.
    logic        stalled = 1'b0;
    logic [63:0] held = '0;
    op_t         mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_hold", {15'd0, issue_valid, issue_rob_idx, issue_opcode, issue_imm,
                      issue_a, issue_b}, held);
            end
            if (issue_valid && issue_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL issue_unexpected: got rob_idx %0h required no issue at %0t",
                             issue_rob_idx, $time);
                end else begin
                    mon_e = expq.pop_front();
                    check("issue_rob_idx", 64'(issue_rob_idx), 64'(mon_e.tag));
                    check("issue_opcode", 64'(issue_opcode), 64'(mon_e.opc));
                    check("issue_imm", 64'(issue_imm), 64'(mon_e.imm));
                    check("issue_a", 64'(issue_a), 64'(mon_e.a));
                    check("issue_b", 64'(issue_b), 64'(mon_e.b));
                end
            end
            stalled = issue_valid && !issue_ready && !flush;
            held = {15'd0, issue_valid, issue_rob_idx, issue_opcode, issue_imm, issue_a, issue_b};
        end
    end

    task automatic idle_inputs();
        in_valid = 1'b0;
        cdb_valid = '0;
        flush = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic disp(input logic [TAG_W-1:0] tag, input bit av, input logic [DATA_W-1:0] a,
                        input logic [TAG_W-1:0] ao, input bit bv, input logic [DATA_W-1:0] b,
                        input logic [TAG_W-1:0] bo);
        in_valid = 1'b1;
        in_rob_idx = tag;
        in_opcode = OPC_W'(tag + 1);
        in_imm = IMM_W'({tag, tag});
        in_a_valid = av;
        in_a_value = a;
        in_a_owner = ao;
        in_b_valid = bv;
        in_b_value = b;
        in_b_owner = bo;
    endtask

    task automatic bcast(input int k, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_valid[k] = 1'b1;
        cdb_tag[k*TAG_W +: TAG_W] = t;
        cdb_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic rand_inputs();
        logic [TAG_W-1:0] t;
        issue_ready = ($urandom_range(99) < 70);
        if ($urandom_range(99) < 10) rob_head = TAG_W'($urandom_range(NTAGS - 1));
        flush = ($urandom_range(149) == 0);
        if ($urandom_range(99) < 60) begin
            do t = TAG_W'($urandom_range(NTAGS - 1)); while (tag_used(t));
            disp(t, 1'($urandom_range(1)), DATA_W'($urandom), TAG_W'($urandom_range(7)),
                 1'($urandom_range(1)), DATA_W'($urandom), TAG_W'($urandom_range(7)));
            in_opcode = OPC_W'($urandom);
            in_imm = IMM_W'($urandom);
        end
        for (int k = 0; k < NUM_CDB; k++) begin
            if ($urandom_range(99) < 30) bcast(k, TAG_W'($urandom_range(7)), DATA_W'($urandom));
        end
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_issue_data", {issue_rob_idx, issue_opcode, issue_imm, issue_a, issue_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Simple ready dispatch, issue two cycles later
        issue_ready = 1'b1;
        disp(4'd3, 1'b1, 16'd5, 4'd0, 1'b1, 16'd7, 4'd0);
        ticks(4);

        // Late wakeup; channel 3 also matches but channel 2 must win
        disp(4'd2, 1'b0, 16'd0, 4'd9, 1'b1, 16'h0055, 4'd0);
        tick();
        bcast(2, 4'd9, 16'h1234);
        bcast(3, 4'd9, 16'hdead);
        ticks(4);

        // Dispatch-time bypass
        disp(4'd9, 1'b1, 16'h0aaa, 4'd0, 1'b0, 16'd0, 4'd5);
        bcast(1, 4'd5, 16'h0abc);
        ticks(4);

        // Fill the queue, wake one, then drain
        disp(4'd4, 1'b0, 16'd0, 4'd10, 1'b1, 16'd1, 4'd0); tick();
        disp(4'd5, 1'b0, 16'd0, 4'd11, 1'b1, 16'd2, 4'd0); tick();
        disp(4'd6, 1'b0, 16'd0, 4'd12, 1'b1, 16'd3, 4'd0); tick();
        disp(4'd7, 1'b0, 16'd0, 4'd13, 1'b1, 16'd4, 4'd0); tick();
        ticks(2);
        bcast(0, 4'd11, 16'hbeef);
        ticks(4);
        bcast(0, 4'd10, 16'h1010);
        bcast(1, 4'd12, 16'h1212);
        bcast(2, 4'd13, 16'h1313);
        ticks(8);

        // Wrap-around age order under a stalled output
        issue_ready = 1'b0;
        rob_head = 4'd14;
        disp(4'd8, 1'b1, 16'h0008, 4'd0, 1'b1, 16'h0080, 4'd0);
        ticks(3);
        disp(4'd1, 1'b1, 16'h0001, 4'd0, 1'b1, 16'h0010, 4'd0); tick();
        disp(4'd15, 1'b1, 16'h000f, 4'd0, 1'b1, 16'h00f0, 4'd0); tick();
        ticks(3);
        issue_ready = 1'b1;
        ticks(5);

        // Flush with entries and a pending output
        issue_ready = 1'b0;
        disp(4'd3, 1'b1, 16'h0333, 4'd0, 1'b1, 16'h3330, 4'd0);
        ticks(3);
        disp(4'd4, 1'b0, 16'd0, 4'd12, 1'b1, 16'd0, 4'd0); tick();
        disp(4'd5, 1'b0, 16'd0, 4'd12, 1'b1, 16'd0, 4'd0); tick();
        disp(4'd6, 1'b0, 16'd0, 4'd12, 1'b1, 16'd0, 4'd0); tick();
        flush = 1'b1;
        tick();
        issue_ready = 1'b1;
        ticks(2);

        // Asynchronous reset in mid-cycle with an output pending
        issue_ready = 1'b0;
        disp(4'd7, 1'b1, 16'h0777, 4'd0, 1'b1, 16'h7770, 4'd0);
        ticks(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_issue_valid", 64'(issue_valid), 64'd0);
        check("async_count", 64'(count), 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd1);
        pool.delete();
        expq.delete();
        m_out_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue_ready = 1'b1;
        rob_head = '0;
        ticks(2);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            rand_inputs();
            tick();
        end

        issue_ready = 1'b1;
        flush = 1'b1;
        ticks(3);
        check("final_pending", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
